// File: rtl/restoring_divider_pkg.sv
// Shared definitions for the restoring divider: FSM states, output-word
// select codes and the default operand width.
package restoring_divider_pkg;

   localparam int DEFAULT_WIDTH = 5;

   typedef enum logic [2:0] {
      IDLE,
      LOAD_X,
      LOAD_Y,
      CALC,
      OUT_Q,
      OUT_R
   } state_t;

   typedef enum logic [1:0] {
      SEL_NONE,
      SEL_Q,
      SEL_R
   } out_sel_t;

endpackage

// File: rtl/restoring_divider_if.sv
// Handshake and operand/result bus of the restoring divider.
// The requester drives start/data_in; the divider returns status and results.
interface restoring_divider_if
   import restoring_divider_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
);

   logic             start;
   logic [WIDTH-1:0] data_in;
   logic             ready;
   logic             valid_out;
   logic             out_rem;
   logic             div_zero;
   logic [WIDTH-1:0] data_out;

   modport master (
      output start,
      output data_in,
      input  ready,
      input  valid_out,
      input  out_rem,
      input  div_zero,
      input  data_out
   );

   modport slave (
      input  start,
      input  data_in,
      output ready,
      output valid_out,
      output out_rem,
      output div_zero,
      output data_out
   );

endinterface

// File: rtl/restoring_divider_datapath.sv
// Datapath of the restoring divider: partial remainder A, dividend/quotient
// register X, divisor Y, the WIDTH+1-bit trial subtractor, the restore
// select and the result-word mux. All sequencing comes from the controller.
module div_datapath
   import restoring_divider_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load_x,
   input  logic             load_y,
   input  logic             shift,
   input  out_sel_t         out_sel,
   input  logic [WIDTH-1:0] data_in,
   output logic [WIDTH-1:0] data_out,
   output logic             div_zero
);

   logic [WIDTH:0]     a;
   logic [WIDTH-1:0]   x;
   logic [WIDTH-1:0]   y;

   logic [2*WIDTH:0]   ax_shift;
   logic [WIDTH:0]     a_shift;
   logic [WIDTH-1:0]   x_shift;
   logic [WIDTH:0]     trial;
   logic               restore;

   // One iteration's combinational step: shift {A,X}, trial-subtract Y, and
   // keep the shifted A whenever the trial result went negative.
   always_comb begin
      ax_shift = {a, x} << 1;
      a_shift  = ax_shift[2*WIDTH:WIDTH];
      x_shift  = ax_shift[WIDTH-1:0];
      trial    = a_shift - {1'b0, y};
      restore  = trial[WIDTH];
   end

   // Operand loads and one restoring iteration per shift cycle; a zero
   // divisor is flagged at load time and simply runs through the same loop.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         a        <= '0;
         x        <= '0;
         y        <= '0;
         div_zero <= 1'b0;
      end else if (load_x) begin
         x <= data_in;
      end else if (load_y) begin
         y        <= data_in;
         a        <= '0;
         div_zero <= (data_in == '0);
      end else if (shift) begin
         if (restore) begin
            a <= a_shift;
            x <= {x_shift[WIDTH-1:1], 1'b0};
         end else begin
            a <= trial;
            x <= {x_shift[WIDTH-1:1], 1'b1};
         end
      end
   end

   // Result-word mux: quotient lives in X, remainder in the low bits of A.
   always_comb begin
      data_out = '0;
      case (out_sel)
         SEL_Q:   data_out = x;
         SEL_R:   data_out = a[WIDTH-1:0];
         default: data_out = '0;
      endcase
   end

endmodule

// File: rtl/restoring_divider.sv
// Restoring divider top: sequences operand capture from the shared bus,
// WIDTH restoring iterations, then presents quotient and remainder on
// consecutive cycles before returning to IDLE.
module restoring_divider
   import restoring_divider_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic                 clk,
   input  logic                 rst,
   restoring_divider_if.slave   bus
);

   localparam int CNT_W = $clog2(WIDTH + 1);

   state_t           state;
   state_t           next_state;
   logic [CNT_W-1:0] count;
   logic             load_x;
   logic             load_y;
   logic             shift;
   out_sel_t         out_sel;
   logic             last_iter;

   assign last_iter = (count == CNT_W'(WIDTH - 1));

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   // Iteration counter: cleared while the divisor loads, advanced per CALC cycle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count <= '0;
      end else if (load_y) begin
         count <= '0;
      end else if (shift) begin
         count <= count + CNT_W'(1);
      end
   end

   // Next-state logic and datapath controls; start only matters in IDLE.
   always_comb begin
      next_state    = state;
      load_x        = 1'b0;
      load_y        = 1'b0;
      shift         = 1'b0;
      out_sel       = SEL_NONE;
      bus.ready     = 1'b0;
      bus.valid_out = 1'b0;
      bus.out_rem   = 1'b0;
      case (state)
         IDLE: begin
            bus.ready = 1'b1;
            if (bus.start) begin
               next_state = LOAD_X;
            end
         end
         LOAD_X: begin
            load_x     = 1'b1;
            next_state = LOAD_Y;
         end
         LOAD_Y: begin
            load_y     = 1'b1;
            next_state = CALC;
         end
         CALC: begin
            shift = 1'b1;
            if (last_iter) begin
               next_state = OUT_Q;
            end
         end
         OUT_Q: begin
            out_sel       = SEL_Q;
            bus.valid_out = 1'b1;
            next_state    = OUT_R;
         end
         OUT_R: begin
            out_sel       = SEL_R;
            bus.valid_out = 1'b1;
            bus.out_rem   = 1'b1;
            next_state    = IDLE;
         end
         default: begin
            next_state = IDLE;
         end
      endcase
   end

   div_datapath #(
      .WIDTH (WIDTH)
   ) u_datapath (
      .clk      (clk),
      .rst      (rst),
      .load_x   (load_x),
      .load_y   (load_y),
      .shift    (shift),
      .out_sel  (out_sel),
      .data_in  (bus.data_in),
      .data_out (bus.data_out),
      .div_zero (bus.div_zero)
   );

endmodule

// File: tb/tb_restoring_divider.sv
// Directed testbench for restoring_divider (WIDTH=5): operation results,
// cycle positions of result words, divide-by-zero, ignored start,
// mid-operation reset and back-to-back operations.
module tb_restoring_divider;

   localparam int W = 5;

   // Expected handshake pattern for one operation:
   // {ready_before, early_valid, early_ready, q_vld, q_rem, r_vld, r_rem, ready_after, valid_after}
   localparam logic [8:0] TIMING_OK = 9'b1_0_0_1_0_1_1_1_0;

   typedef struct packed {
      logic [8:0]   timing;
      logic [W-1:0] q;
      logic [W-1:0] r;
      logic         dz;
   } obs_t;

   logic clk;
   logic rst;
   int   checks;
   int   failures;

   restoring_divider_if #(.WIDTH(W)) bus ();

   restoring_divider #(.WIDTH(W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   // Free-running 10 ns clock.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Runs one operation starting from IDLE and records what the bus showed
   // at each cycle position (sampled 1 ns after each rising edge).
   task automatic apply_stimulus(input logic [W-1:0] dividend, input logic [W-1:0] divisor,
                                 input int pulse_after, output obs_t o);
      logic ready_before, early_valid, early_ready;
      logic q_vld, q_rem, r_vld, r_rem, ready_after, valid_after;
      early_valid = 1'b0;
      early_ready = 1'b0;
      for (int i = 0; i < 20 && bus.ready !== 1'b1; i++) begin
         @(posedge clk); #1;
      end
      ready_before = (bus.ready === 1'b1);
      bus.start   = 1'b1;
      bus.data_in = '0;
      @(posedge clk); #1;                       // edge 0
      bus.start   = 1'b0;
      bus.data_in = dividend;
      early_valid |= (bus.valid_out !== 1'b0);
      early_ready |= (bus.ready !== 1'b0);
      @(posedge clk); #1;                       // edge 1
      bus.data_in = divisor;
      early_valid |= (bus.valid_out !== 1'b0);
      early_ready |= (bus.ready !== 1'b0);
      @(posedge clk); #1;                       // edge 2
      bus.data_in = '0;
      early_valid |= (bus.valid_out !== 1'b0);
      early_ready |= (bus.ready !== 1'b0);
      for (int e = 3; e <= 6; e++) begin
         @(posedge clk); #1;
         bus.start = (e == pulse_after);
         early_valid |= (bus.valid_out !== 1'b0);
         early_ready |= (bus.ready !== 1'b0);
      end
      @(posedge clk); #1;                       // edge 7
      bus.start = 1'b0;
      q_vld = bus.valid_out;
      q_rem = bus.out_rem;
      o.q   = bus.data_out;
      early_ready |= (bus.ready !== 1'b0);
      @(posedge clk); #1;                       // edge 8
      r_vld = bus.valid_out;
      r_rem = bus.out_rem;
      o.r   = bus.data_out;
      o.dz  = bus.div_zero;
      early_ready |= (bus.ready !== 1'b0);
      @(posedge clk); #1;                       // edge 9
      ready_after = bus.ready;
      valid_after = bus.valid_out;
      o.timing = {ready_before, early_valid, early_ready, q_vld, q_rem,
                  r_vld, r_rem, ready_after, valid_after};
   endtask

   task automatic test_reset();
      rst = 1'b1;
      bus.start = 1'b0;
      bus.data_in = '0;
      #3;
      checks += 5;
      if (bus.ready !== 1'b1) begin failures++; $display("[TB] FAIL reset_ready got=%b want=1", bus.ready); end
      if (bus.valid_out !== 1'b0) begin failures++; $display("[TB] FAIL reset_valid got=%b want=0", bus.valid_out); end
      if (bus.out_rem !== 1'b0) begin failures++; $display("[TB] FAIL reset_out_rem got=%b want=0", bus.out_rem); end
      if (bus.data_out !== 5'd0) begin failures++; $display("[TB] FAIL reset_data_out got=%0d want=0", bus.data_out); end
      if (bus.div_zero !== 1'b0) begin failures++; $display("[TB] FAIL reset_div_zero got=%b want=0", bus.div_zero); end
      @(posedge clk); @(posedge clk); #1;
      rst = 1'b0;
   endtask

   task automatic test_basic();
      obs_t o;
      apply_stimulus(5'd23, 5'd4, 0, o);
      checks += 4;
      if (o.timing !== TIMING_OK) begin failures++; $display("[TB] FAIL basic_timing got=%b want=%b", o.timing, TIMING_OK); end
      if (o.q !== 5'd5) begin failures++; $display("[TB] FAIL basic_quotient got=%0d want=5", o.q); end
      if (o.r !== 5'd3) begin failures++; $display("[TB] FAIL basic_remainder got=%0d want=3", o.r); end
      if (o.dz !== 1'b0) begin failures++; $display("[TB] FAIL basic_div_zero got=%b want=0", o.dz); end
   endtask

   task automatic test_max_dividend();
      obs_t o;
      apply_stimulus(5'd31, 5'd1, 0, o);
      checks += 3;
      if (o.timing !== TIMING_OK) begin failures++; $display("[TB] FAIL max_timing got=%b want=%b", o.timing, TIMING_OK); end
      if (o.q !== 5'd31) begin failures++; $display("[TB] FAIL max_quotient got=%0d want=31", o.q); end
      if (o.r !== 5'd0) begin failures++; $display("[TB] FAIL max_remainder got=%0d want=0", o.r); end
   endtask

   task automatic test_small_dividend();
      obs_t o;
      apply_stimulus(5'd3, 5'd9, 0, o);
      checks += 3;
      if (o.timing !== TIMING_OK) begin failures++; $display("[TB] FAIL small_timing got=%b want=%b", o.timing, TIMING_OK); end
      if (o.q !== 5'd0) begin failures++; $display("[TB] FAIL small_quotient got=%0d want=0", o.q); end
      if (o.r !== 5'd3) begin failures++; $display("[TB] FAIL small_remainder got=%0d want=3", o.r); end
   endtask

   task automatic test_div_zero();
      obs_t o;
      apply_stimulus(5'd7, 5'd0, 0, o);
      checks += 5;
      if (o.timing !== TIMING_OK) begin failures++; $display("[TB] FAIL dz_timing got=%b want=%b", o.timing, TIMING_OK); end
      if (o.dz !== 1'b1) begin failures++; $display("[TB] FAIL dz_flag got=%b want=1", o.dz); end
      if (o.q !== 5'd31) begin failures++; $display("[TB] FAIL dz_quotient got=%0d want=31", o.q); end
      if (o.r !== 5'd7) begin failures++; $display("[TB] FAIL dz_remainder got=%0d want=7", o.r); end
      @(posedge clk); #1;
      if (bus.div_zero !== 1'b1) begin failures++; $display("[TB] FAIL dz_hold_idle got=%b want=1", bus.div_zero); end
   endtask

   task automatic test_reset_clears_dz();
      @(negedge clk);
      rst = 1'b1;
      #1;
      checks++;
      if (bus.div_zero !== 1'b0) begin failures++; $display("[TB] FAIL async_reset_dz got=%b want=0", bus.div_zero); end
      @(posedge clk); #1;
      rst = 1'b0;
   endtask

   task automatic test_start_ignored();
      obs_t o;
      logic extra;
      apply_stimulus(5'd20, 5'd6, 4, o);
      extra = 1'b0;
      for (int i = 0; i < 12; i++) begin
         @(posedge clk); #1;
         extra |= (bus.ready !== 1'b1) || (bus.valid_out !== 1'b0);
      end
      checks += 4;
      if (o.timing !== TIMING_OK) begin failures++; $display("[TB] FAIL ignore_timing got=%b want=%b", o.timing, TIMING_OK); end
      if (o.q !== 5'd3) begin failures++; $display("[TB] FAIL ignore_quotient got=%0d want=3", o.q); end
      if (o.r !== 5'd2) begin failures++; $display("[TB] FAIL ignore_remainder got=%0d want=2", o.r); end
      if (extra !== 1'b0) begin failures++; $display("[TB] FAIL ignore_no_second_op got=%b want=0", extra); end
   endtask

   task automatic test_reset_mid_op();
      obs_t o;
      logic [3:0] in_reset;
      bus.start   = 1'b1;
      bus.data_in = '0;
      @(posedge clk); #1;                       // edge 0
      bus.start   = 1'b0;
      bus.data_in = 5'd25;
      @(posedge clk); #1;                       // edge 1
      bus.data_in = 5'd5;
      @(posedge clk); #1;                       // edge 2
      bus.data_in = '0;
      @(posedge clk); #1;                       // edge 3
      @(posedge clk); #1;                       // edge 4: third CALC cycle
      rst = 1'b1;
      #1;
      in_reset = {bus.ready, bus.valid_out, bus.out_rem, (bus.data_out == 5'd0)};
      @(posedge clk); #1;
      rst = 1'b0;
      apply_stimulus(5'd18, 5'd18, 0, o);
      checks += 4;
      if (in_reset !== 4'b1001) begin failures++; $display("[TB] FAIL midrst_outputs got=%b want=1001", in_reset); end
      if (o.timing !== TIMING_OK) begin failures++; $display("[TB] FAIL midrst_timing got=%b want=%b", o.timing, TIMING_OK); end
      if (o.q !== 5'd1) begin failures++; $display("[TB] FAIL midrst_quotient got=%0d want=1", o.q); end
      if (o.r !== 5'd0) begin failures++; $display("[TB] FAIL midrst_remainder got=%0d want=0", o.r); end
   endtask

   task automatic test_back_to_back();
      logic [W-1:0] q1, r1, q2, r2;
      logic [1:0]   f1, f2, f3, f4;
      logic         rdy9, rdy10, rdy19;
      bus.start   = 1'b1;
      bus.data_in = '0;
      @(posedge clk); #1;                       // edge 0
      bus.data_in = 5'd30;
      @(posedge clk); #1;                       // edge 1
      bus.data_in = 5'd7;
      @(posedge clk); #1;                       // edge 2
      bus.data_in = '0;
      for (int e = 3; e <= 6; e++) begin
         @(posedge clk); #1;
      end
      @(posedge clk); #1;                       // edge 7
      q1 = bus.data_out; f1 = {bus.valid_out, bus.out_rem};
      @(posedge clk); #1;                       // edge 8
      r1 = bus.data_out; f2 = {bus.valid_out, bus.out_rem};
      @(posedge clk); #1;                       // edge 9
      rdy9 = bus.ready;
      @(posedge clk); #1;                       // edge 10: second op begins
      rdy10 = bus.ready;
      bus.data_in = 5'd17;
      @(posedge clk); #1;                       // edge 11
      bus.data_in = 5'd3;
      @(posedge clk); #1;                       // edge 12
      bus.data_in = '0;
      bus.start   = 1'b0;
      for (int e = 13; e <= 16; e++) begin
         @(posedge clk); #1;
      end
      @(posedge clk); #1;                       // edge 17
      q2 = bus.data_out; f3 = {bus.valid_out, bus.out_rem};
      @(posedge clk); #1;                       // edge 18
      r2 = bus.data_out; f4 = {bus.valid_out, bus.out_rem};
      @(posedge clk); #1;                       // edge 19
      rdy19 = bus.ready;
      checks += 7;
      if ({f1, f2, f3, f4} !== 8'b10_11_10_11) begin failures++; $display("[TB] FAIL b2b_flags got=%b want=10111011", {f1, f2, f3, f4}); end
      if (q1 !== 5'd4) begin failures++; $display("[TB] FAIL b2b_q1 got=%0d want=4", q1); end
      if (r1 !== 5'd2) begin failures++; $display("[TB] FAIL b2b_r1 got=%0d want=2", r1); end
      if ({rdy9, rdy10} !== 2'b10) begin failures++; $display("[TB] FAIL b2b_ready_gap got=%b want=10", {rdy9, rdy10}); end
      if (q2 !== 5'd5) begin failures++; $display("[TB] FAIL b2b_q2 got=%0d want=5", q2); end
      if (r2 !== 5'd2) begin failures++; $display("[TB] FAIL b2b_r2 got=%0d want=2", r2); end
      if (rdy19 !== 1'b1) begin failures++; $display("[TB] FAIL b2b_ready_end got=%b want=1", rdy19); end
   endtask

   // Test sequence.
   initial begin
      checks   = 0;
      failures = 0;
      test_reset();
      test_basic();
      test_max_dividend();
      test_small_dividend();
      test_div_zero();
      test_reset_clears_dz();
      test_start_ignored();
      test_reset_mid_op();
      test_back_to_back();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
